// File: rtl/custom_sched_pkg.sv
// custom_sched_pkg: shared state encoding and default constants for the convolution layer scheduler
package custom_sched_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_MAC   = 3'd4,
        S_STORE = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } sched_state_t;
    localparam int DEF_NUM_TILES    = 4;
    localparam int DEF_FLUSH_CYCLES = 1;
    localparam int DEF_MAC_CYCLES   = 3;
    localparam int DEF_NUM_OUT      = 4;
    localparam int LOADER_STAGES    = 27;
endpackage

// File: rtl/custom_sched_step_cnt.sv
// custom_sched_step_cnt: loadable down-counter with zero flag timing FLUSH, MAC and STORE phases
// Ports: clk, rst (async active-low), load/load_val (reload), dec (count down), zero (count is 0)
module custom_sched_step_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/custom_conv_scheduler.sv
// custom_conv_scheduler: per-layer sequencer driving loader, MAC array and output memory, tile by tile
// Ports: clk, rst (async active-low), start_i/abort_i (host control), loader_done_i (loader finished),
//   loader_en_o, acc_clr_o, mac_en_o, wr_en_o/wr_sel_o/wr_addr_o (output memory), tile_idx_o, busy_o, done_o.
// Optional CUSTOM_SCHED_PERF_EN adds perf_cycles_o, the busy-cycle count of the last/current layer.
module custom_conv_scheduler
    import custom_sched_pkg::*;
#(
    parameter int NUM_TILES    = DEF_NUM_TILES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MAC_CYCLES   = DEF_MAC_CYCLES,
    parameter int NUM_OUT      = DEF_NUM_OUT,
    parameter int OUT_ADDR_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  loader_done_i,
    output logic                  loader_en_o,
    output logic                  acc_clr_o,
    output logic                  mac_en_o,
    output logic                  wr_en_o,
    output logic [1:0]            wr_sel_o,
    output logic [OUT_ADDR_W-1:0] wr_addr_o,
    output logic [3:0]            tile_idx_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef CUSTOM_SCHED_PERF_EN
    ,
    output logic [15:0]           perf_cycles_o
`endif
);
    sched_state_t state;
    logic         cnt_load, cnt_dec, cnt_zero;
    logic [3:0]   cnt_val;

    // The step counter is reloaded on each phase entry with (duration-1) and the phase ends when it reads zero.
    always_comb begin
        cnt_load = (state == S_LOAD && loader_done_i) || ((state == S_FLUSH || state == S_MAC) && cnt_zero);
        cnt_dec  = (state == S_FLUSH || state == S_MAC || state == S_STORE) && !cnt_zero;
        cnt_val  = state == S_LOAD  ? 4'(FLUSH_CYCLES - 1) :
                   state == S_FLUSH ? 4'(MAC_CYCLES - 1) : 4'(NUM_OUT - 1);
    end

    custom_sched_step_cnt #(.W(4)) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Outputs are assigned together with the state they belong to, so they are all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            loader_en_o <= 1'b0;
            acc_clr_o   <= 1'b0;
            mac_en_o    <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_sel_o    <= '0;
            wr_addr_o   <= '0;
            tile_idx_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (abort_i) begin
            state       <= S_IDLE;
            loader_en_o <= 1'b0;
            acc_clr_o   <= 1'b0;
            mac_en_o    <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_sel_o    <= '0;
            wr_addr_o   <= '0;
            tile_idx_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            acc_clr_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE: if (start_i) begin
                    state      <= S_CLEAR;
                    tile_idx_o <= '0;
                    acc_clr_o  <= 1'b1;
                    busy_o     <= 1'b1;
                end
                S_CLEAR: begin
                    state       <= S_LOAD;
                    loader_en_o <= 1'b1;
                end
                S_LOAD: if (loader_done_i) begin
                    state       <= S_FLUSH;
                    loader_en_o <= 1'b0;
                end
                S_FLUSH: if (cnt_zero) begin
                    state    <= S_MAC;
                    mac_en_o <= 1'b1;
                end
                S_MAC: if (cnt_zero) begin
                    state     <= S_STORE;
                    mac_en_o  <= 1'b0;
                    wr_en_o   <= 1'b1;
                    wr_sel_o  <= '0;
                    wr_addr_o <= OUT_ADDR_W'({tile_idx_o, 2'b00});
                end
                S_STORE: if (cnt_zero) begin
                    state   <= S_NEXT;
                    wr_en_o <= 1'b0;
                end else begin
                    wr_sel_o  <= wr_sel_o + 2'd1;
                    wr_addr_o <= wr_addr_o + OUT_ADDR_W'(1);
                end
                S_NEXT: if (tile_idx_o == 4'(NUM_TILES - 1)) begin
                    state  <= S_DONE;
                    done_o <= 1'b1;
                end else begin
                    state      <= S_CLEAR;
                    tile_idx_o <= tile_idx_o + 4'd1;
                    acc_clr_o  <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CUSTOM_SCHED_PERF_EN
    // Counts the edges spent busy up to the DONE cycle, so the DONE-cycle value equals the layer latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) perf_cycles_o <= '0;
        else if (abort_i) perf_cycles_o <= perf_cycles_o;
        else if (state == S_IDLE && start_i) perf_cycles_o <= '0;
        else if (state != S_IDLE && state != S_DONE) perf_cycles_o <= perf_cycles_o + 16'd1;
    end
`endif
endmodule

// File: doc/custom_conv_scheduler.md
Name: custom_conv_scheduler

Overview:
- Top-level sequencer for one convolution layer built from the custom data loader, the 4-lane MAC/accumulator array and the output memory.
- Per tile: clears accumulators, runs the loader until it reports done, drains the loader's 1-cycle control buffering, enables MAC, then writes the 4 accumulator results to output memory.
- Repeats for NUM_TILES tiles and is driven by a single start/done handshake from the host/testbench.

Parameters:
- NUM_TILES, 4, tiles per layer (1..16).
- FLUSH_CYCLES, 1, cycles waited after loader done, covering the loader's registered control outputs (1..4).
- MAC_CYCLES, 3, cycles mac_en_o stays high per tile (1..15).
- NUM_OUT, 4, accumulator lanes written per tile (fixed 4).
- OUT_ADDR_W, 6, output memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  start layer; sampled only in IDLE.
- abort_i  in  1  synchronous abort; any state goes to IDLE.
- loader_done_i  in  1  is_done from data loader.
- loader_en_o  out  1  data loader enable.
- acc_clr_o  out  1  one-cycle accumulator clear.
- mac_en_o  out  1  MAC array enable.
- wr_en_o  out  1  output memory write strobe.
- wr_sel_o  out  2  accumulator lane being written.
- wr_addr_o  out  OUT_ADDR_W  output memory address.
- tile_idx_o  out  4  current tile index.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at layer completion.

Behaviour:
- All outputs are registered (Moore). Reset value of every output is 0; state is IDLE; tile and step counters are 0.
- Reset assertion mid-operation forces reset values immediately, with no write completion.
- States: IDLE, CLEAR, LOAD, FLUSH, MAC, STORE, NEXT, DONE.
- IDLE: start_i=1 goes to CLEAR and sets tile=0. start_i while busy is ignored, with no queuing.
- CLEAR: acc_clr_o=1 for exactly 1 cycle, then LOAD.
- LOAD: loader_en_o=1. When loader_done_i is sampled high, go to FLUSH; loader_en_o is 0 from that next cycle.
  - loader_done_i in any other state is ignored.
  - loader_done_i high in the first LOAD cycle is still honoured.
- FLUSH: FLUSH_CYCLES cycles with all strobes low, then MAC.
- MAC: mac_en_o=1 for exactly MAC_CYCLES consecutive cycles, then STORE.
- STORE: NUM_OUT consecutive cycles with wr_en_o=1.
  - wr_sel_o runs 0,1,2,3.
  - wr_addr_o = tile*NUM_OUT + wr_sel_o, truncated to OUT_ADDR_W bits (wraps modulo 2^OUT_ADDR_W).
  - Then NEXT.
- NEXT (1 cycle): if tile==NUM_TILES-1, go to DONE; otherwise tile+1 and go to CLEAR.
- DONE: done_o=1 for 1 cycle, then IDLE. done_o coincides with the cycle after NEXT.
- abort_i has priority over every transition, including start_i in IDLE. The next state is IDLE and all strobes are 0 next cycle. done_o is not pulsed; tile_idx_o resets to 0.
- Per-tile latency with loader done after L LOAD cycles: 1 + L + FLUSH_CYCLES + MAC_CYCLES + NUM_OUT + 1 cycles.
- Counters are saturating-free; widths are sized to parameter maxima.

Optional Feature:
- Macro CUSTOM_SCHED_PERF_EN.
- Defined: adds output perf_cycles_o (16 bits).
  - Clears to 0 on the start_i acceptance cycle and increments every cycle while busy_o=1.
  - Holds its value in IDLE; reset value 0; wraps at 16'hFFFF.
  - Abort freezes the count.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package custom_sched_pkg holds:
  - the state enumeration (3-bit encoding, IDLE=0);
  - default constants for NUM_TILES, FLUSH_CYCLES, MAC_CYCLES, NUM_OUT;
  - the LOADER_STAGES=27 constant shared with the loader.
- One natural sub-module, custom_sched_step_cnt: a loadable down-counter with a zero flag, reused for the FLUSH, MAC and STORE durations.
- The FSM and tile counter stay in the top module.

Test Plan:
- Reset: rst=0 mid-STORE at tile 2 -> all outputs 0 in the same cycle; state IDLE after release; a fresh start_i begins at tile 0.
- Nominal run with defaults, loader_done_i after 27 LOAD cycles:
  - each tile takes 37 cycles;
  - 16 writes total, at addresses 0..15 with wr_sel_o cycling 0..3;
  - done_o is a single pulse 148 cycles after start acceptance.
- Early done: loader_done_i=1 on the first LOAD cycle -> loader_en_o high exactly 1 cycle; FLUSH follows.
- Spurious inputs:
  - loader_done_i during MAC -> no state change;
  - start_i during LOAD -> ignored, tile_idx_o unchanged.
- Abort: abort_i in MAC of tile 1 -> next cycle IDLE; mac_en_o=0, busy_o=0, no done_o, no further writes.
- Perf (CUSTOM_SCHED_PERF_EN defined): nominal run -> perf_cycles_o=148 after DONE; it holds 148 in IDLE and clears to 0 on the next start.
